// File: rtl/arp_reply_gen.sv
// ARP reply generator: filters parsed ARP requests for the local IP and streams a 7-word reply.
// Optional statistics counters are built only when ARP_STATS_EN is defined.
module arp_reply_gen #(
  parameter logic [47:0] MY_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] MY_IP  = 32'hC0A8_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fields_valid,
  input  logic [15:0] hdr_type,
  input  logic [15:0] proto_type,
  input  logic [7:0]  hdw_length,
  input  logic [7:0]  pro_length,
  input  logic [15:0] operation,
  input  logic [47:0] send_hdr_addr,
  input  logic [31:0] send_ip_addr,
  input  logic [47:0] target_hdr_addr,
  input  logic [31:0] target_ip_addr,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [15:0] cnt_reply,
  output logic [15:0] cnt_drop,
  output logic [15:0] cnt_filt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;

  logic match;
  logic hs;
  logic last_hs;
  logic accept;
  logic unused_tha;

  // THA is deliberately not part of the filter or the reply.
  assign unused_tha = ^target_hdr_addr;

  assign match   = (hdr_type == 16'h0001) && (proto_type == 16'h0800)
                && (hdw_length == 8'd6) && (pro_length == 8'd4)
                && (operation == 16'h0001) && (target_ip_addr == MY_IP);
  assign hs      = (state_q == SEND) && tx_ready;
  assign last_hs = hs && (idx_q == 3'd6);
  assign accept  = (state_q == IDLE) && fields_valid && match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Requester addresses are pure data; they are only meaningful while in SEND.
  always_ff @(posedge clk) begin
    sha_q <= sha_d;
    spa_q <= spa_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sha_d   = sha_q;
    spa_d   = spa_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = 3'd0;
          sha_d   = send_hdr_addr;
          spa_d   = send_ip_addr;
        end
      end
      SEND: begin
        if (last_hs) begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end else if (hs) begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    busy     = 1'b0;
    tx_data  = 32'h0000_0000;
    if (state_q == SEND) begin
      tx_valid = 1'b1;
      busy     = 1'b1;
      tx_last  = (idx_q == 3'd6);
      case (idx_q)
        3'd0:    tx_data = {16'h0001, 16'h0800};
        3'd1:    tx_data = {8'd6, 8'd4, 16'h0002};
        3'd2:    tx_data = MY_MAC[47:16];
        3'd3:    tx_data = {MY_MAC[15:0], MY_IP[31:16]};
        3'd4:    tx_data = {MY_IP[15:0], sha_q[47:32]};
        3'd5:    tx_data = sha_q[31:0];
        3'd6:    tx_data = spa_q;
        default: tx_data = 32'h0000_0000;
      endcase
    end
  end

`ifdef ARP_STATS_EN
  logic [15:0] cnt_reply_q, cnt_reply_d;
  logic [15:0] cnt_drop_q, cnt_drop_d;
  logic [15:0] cnt_filt_q, cnt_filt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    cnt_reply_d = cnt_reply_q;
    cnt_drop_d  = cnt_drop_q;
    cnt_filt_d  = cnt_filt_q;
    if (last_hs)
      cnt_reply_d = sat_inc(cnt_reply_q);
    if (fields_valid && match && (state_q == SEND))
      cnt_drop_d = sat_inc(cnt_drop_q);
    if (fields_valid && !match)
      cnt_filt_d = sat_inc(cnt_filt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reply_q <= 16'd0;
      cnt_drop_q  <= 16'd0;
      cnt_filt_q  <= 16'd0;
    end else begin
      cnt_reply_q <= cnt_reply_d;
      cnt_drop_q  <= cnt_drop_d;
      cnt_filt_q  <= cnt_filt_d;
    end
  end

  assign cnt_reply = cnt_reply_q;
  assign cnt_drop  = cnt_drop_q;
  assign cnt_filt  = cnt_filt_q;
`else
  assign cnt_reply = 16'h0000;
  assign cnt_drop  = 16'h0000;
  assign cnt_filt  = 16'h0000;
`endif

endmodule
